// File: rtl/alu_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc_if
// Brief    : Operand/result handshake bundle for the multi-cycle execute ALU.
//            master = issuing stage (ID/EX side + consumer), slave = ALU.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       exe_cmd;
    logic [WIDTH-1:0] val1;
    logic [WIDTH-1:0] val2;
    logic [WIDTH-1:0] val3;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_result;
    logic             n;
    logic             z;
    logic             c;
    logic             v;
    logic             illegal;

    modport master (
        output in_valid, exe_cmd, val1, val2, val3, c_in, out_ready,
        input  in_ready, out_valid, alu_result, n, z, c, v, illegal
    );

    modport slave (
        input  in_valid, exe_cmd, val1, val2, val3, c_in, out_ready,
        output in_ready, out_valid, alu_result, n, z, c, v, illegal
    );
endinterface
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc
// Brief    : Multi-cycle execute-stage ALU. Single-cycle data-processing ops
//            plus an optional iterative shift-add MUL/MLA unit, behind a
//            valid/ready handshake. Result and NZCV flags are registered and
//            held until taken.
// Config   : define ALU_MC_MUL_EN to build the MUL/MLA unit; otherwise
//            opcodes 1010/1011 are reported as illegal.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_mc_if.slave  alu_if
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd2;
`ifdef ALU_MC_MUL_EN
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam int         CNT_W  = $clog2(WIDTH);
    localparam logic [3:0] OP_MUL = 4'b1010;
    localparam logic [3:0] OP_MLA = 4'b1011;
`endif
    localparam logic [3:0] OP_MOV = 4'b0001;
    localparam logic [3:0] OP_MVN = 4'b1001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_ADC = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SBC = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b0110;
    localparam logic [3:0] OP_ORR = 4'b0111;
    localparam logic [3:0] OP_EOR = 4'b1000;

    logic [1:0]       state_q, state_d;
    logic             w_in_ready, w_out_valid, w_accept, w_is_mul, w_mul_last;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH:0]   w_sum;
    logic             w_c, w_v, w_ill;
    logic [WIDTH-1:0] result_q;
    logic             n_q, z_q, c_q, v_q, ill_q;

`ifdef ALU_MC_MUL_EN
    logic [WIDTH-1:0] mcand_q, mplier_q, acc_q, w_acc_next;
    logic [CNT_W-1:0] cnt_q;
    logic             cin_q;

    assign w_is_mul   = (alu_if.exe_cmd == OP_MUL) || (alu_if.exe_cmd == OP_MLA);
    assign w_mul_last = (state_q == S_MUL) && (cnt_q == CNT_W'(WIDTH - 1));
    assign w_acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
`else
    logic unused_val3;

    assign w_is_mul    = 1'b0;
    assign w_mul_last  = 1'b0;
    assign unused_val3 = ^alu_if.val3;
`endif

    assign w_accept = alu_if.in_valid && w_in_ready;

    // State register; reset discards any multiply in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: HOLD may accept a new op on the same edge it is taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (w_accept) state_d = w_is_mul ? 2'd1 : S_HOLD;
`ifdef ALU_MC_MUL_EN
            S_MUL:  if (w_mul_last) state_d = S_HOLD;
`endif
            S_HOLD: begin
                if (w_accept)              state_d = w_is_mul ? 2'd1 : S_HOLD;
                else if (alu_if.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        w_in_ready  = (state_q == S_IDLE) || ((state_q == S_HOLD) && alu_if.out_ready);
        w_out_valid = (state_q == S_HOLD);
    end

    // Single-cycle datapath; subtraction is a + ~b + carry so c is NOT borrow.
    always_comb begin
        w_res = '0;
        w_sum = '0;
        w_c   = alu_if.c_in;
        w_v   = 1'b0;
        w_ill = 1'b0;
        case (alu_if.exe_cmd)
            OP_MOV: w_res = alu_if.val2;
            OP_MVN: w_res = ~alu_if.val2;
            OP_ADD, OP_ADC: begin
                w_sum = {1'b0, alu_if.val1} + {1'b0, alu_if.val2}
                      + {{WIDTH{1'b0}}, (alu_if.exe_cmd == OP_ADC) && alu_if.c_in};
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (alu_if.val1[WIDTH-1] == alu_if.val2[WIDTH-1])
                     && (w_res[WIDTH-1] != alu_if.val1[WIDTH-1]);
            end
            OP_SUB, OP_SBC: begin
                w_sum = {1'b0, alu_if.val1} + {1'b0, ~alu_if.val2}
                      + {{WIDTH{1'b0}}, (alu_if.exe_cmd == OP_SUB) || alu_if.c_in};
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (alu_if.val1[WIDTH-1] != alu_if.val2[WIDTH-1])
                     && (w_res[WIDTH-1] != alu_if.val1[WIDTH-1]);
            end
            OP_AND: w_res = alu_if.val1 & alu_if.val2;
            OP_ORR: w_res = alu_if.val1 | alu_if.val2;
            OP_EOR: w_res = alu_if.val1 ^ alu_if.val2;
            default: w_ill = 1'b1;
        endcase
    end

`ifdef ALU_MC_MUL_EN
    // Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            cin_q    <= 1'b0;
        end else if (w_accept && w_is_mul) begin
            mcand_q  <= alu_if.val1;
            mplier_q <= alu_if.val2;
            acc_q    <= (alu_if.exe_cmd == OP_MLA) ? alu_if.val3 : '0;
            cnt_q    <= '0;
            cin_q    <= alu_if.c_in;
        end else if (state_q == S_MUL) begin
            acc_q    <= w_acc_next;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
        end
    end
`endif

    // Result/flag registers: loaded on single-cycle accept or multiply completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            if (w_accept && !w_is_mul) begin
                result_q <= w_res;
                n_q      <= w_res[WIDTH-1];
                z_q      <= (w_res == '0);
                c_q      <= w_c;
                v_q      <= w_v;
                ill_q    <= w_ill;
            end
`ifdef ALU_MC_MUL_EN
            if (w_mul_last) begin
                result_q <= w_acc_next;
                n_q      <= w_acc_next[WIDTH-1];
                z_q      <= (w_acc_next == '0);
                c_q      <= cin_q;
                v_q      <= 1'b0;
                ill_q    <= 1'b0;
            end
`endif
        end
    end

    assign alu_if.in_ready   = w_in_ready;
    assign alu_if.out_valid  = w_out_valid;
    assign alu_if.alu_result = result_q;
    assign alu_if.n          = n_q;
    assign alu_if.z          = z_q;
    assign alu_if.c          = c_q;
    assign alu_if.v          = v_q;
    assign alu_if.illegal    = ill_q;
endmodule
`default_nettype wire
